// File: rtl/dsky_serial_rx.sv
// dsky_serial_rx: 8N1 UART receiver + frame parser feeding the five DSKY/AXI 15-bit input words.
// Latency: register write and upd_valid pulse one cycle after the final byte's stop-bit mid-sample.
// Backpressure: none; the line is free-running, rejected bytes/frames are dropped and counted.
// Option: define DSKY_RX_CHECKSUM_EN for 5-byte frames with trailing csum; default is 4-byte frames.
module dsky_serial_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic [14:0] DSKY_VERB_data,
  output logic [14:0] DSKY_NOUN_data,
  output logic [14:0] AXI_MISSION_TIME_data,
  output logic [14:0] AXI_APOGEE_data,
  output logic [14:0] AXI_PERIGEE_data,
  output logic        upd_valid,
  output logic [2:0]  upd_sel,
  output logic [7:0]  err_count
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TMO  = TIMEOUT_BITS * CPB;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TMO + 1);
`ifdef DSKY_RX_CHECKSUM_EN
  localparam int HW   = 8;  // hi[7] takes part in the checksum
`else
  localparam int HW   = 7;  // hi[7] is ignored entirely
`endif

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [2:0] {
    P_HUNT, P_ID, P_HI, P_LO
`ifdef DSKY_RX_CHECKSUM_EN
    , P_CSUM
`endif
  } pstate_t;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  bstate_t       bstate_q, bstate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, frame_err;

  pstate_t       pstate_q, pstate_d;
  logic [2:0]    id_q, id_d;
  logic [HW-1:0] hi_q, hi_d;
`ifdef DSKY_RX_CHECKSUM_EN
  logic [7:0]    lo_q, lo_d;
`endif
  logic [TW-1:0] tmo_q, tmo_d;
  logic [14:0]   regs_q [5];
  logic [14:0]   regs_d [5];
  logic          upd_valid_q, upd_valid_d;
  logic [2:0]    upd_sel_q, upd_sel_d;
  logic [7:0]    err_q, err_d;
  logic          err_evt, commit;
  logic [14:0]   commit_word;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_comb begin
    rx_s1_d   = rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
  end

  // Bit engine: start qualification at half bit, then 8 data bits and stop at full-bit spacing.
  // The edge-detect delay offsets the sync delay, so samples land near bit centres.
  always_comb begin
    bstate_d   = bstate_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (bstate_q)
      B_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          bstate_d = B_START;
          cnt_d    = '0;
        end
      end
      B_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d    = '0;
          bit_d    = '0;
          bstate_d = rx_s2_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) bstate_d = B_STOP;
          else               bit_d    = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d      = '0;
          bstate_d   = B_IDLE;
          byte_valid = rx_s2_q;
          frame_err  = !rx_s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  // Frame parser: header hunt, field capture, inter-byte timeout, commit and error counting.
  always_comb begin
    pstate_d    = pstate_q;
    id_d        = id_q;
    hi_d        = hi_q;
`ifdef DSKY_RX_CHECKSUM_EN
    lo_d        = lo_q;
`endif
    regs_d      = regs_q;
    upd_valid_d = 1'b0;
    upd_sel_d   = upd_sel_q;
    err_d       = err_q;
    err_evt     = 1'b0;
    commit      = 1'b0;
    commit_word = '0;
    tmo_d       = (pstate_q == P_HUNT || byte_valid) ? '0 : tmo_q + 1'b1;

    if (frame_err) begin
      err_evt  = 1'b1;
      pstate_d = P_HUNT;
    end else if (byte_valid) begin
      case (pstate_q)
        P_HUNT: if (shift_q == 8'hA5) pstate_d = P_ID;
        P_ID: begin
          if (shift_q > 8'd4) begin
            err_evt  = 1'b1;
            pstate_d = P_HUNT;
          end else begin
            id_d     = shift_q[2:0];
            pstate_d = P_HI;
          end
        end
        P_HI: begin
          hi_d     = shift_q[HW-1:0];
          pstate_d = P_LO;
        end
`ifdef DSKY_RX_CHECKSUM_EN
        P_LO: begin
          lo_d     = shift_q;
          pstate_d = P_CSUM;
        end
        P_CSUM: begin
          pstate_d = P_HUNT;
          if (shift_q == ({5'b0, id_q} ^ hi_q ^ lo_q)) begin
            commit      = 1'b1;
            commit_word = {hi_q[6:0], lo_q};
          end else begin
            err_evt = 1'b1;
          end
        end
`else
        P_LO: begin
          pstate_d    = P_HUNT;
          commit      = 1'b1;
          commit_word = {hi_q, shift_q};
        end
`endif
        default: pstate_d = P_HUNT;
      endcase
    end else if (pstate_q != P_HUNT && tmo_q == TW'(TMO - 1)) begin
      err_evt  = 1'b1;
      pstate_d = P_HUNT;
    end

    if (commit) begin
      regs_d[id_q] = commit_word;
      upd_valid_d  = 1'b1;
      upd_sel_d    = id_q;
    end
    if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  // State registers; reset aborts any partial byte or frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      bstate_q    <= B_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pstate_q    <= P_HUNT;
      id_q        <= '0;
      hi_q        <= '0;
`ifdef DSKY_RX_CHECKSUM_EN
      lo_q        <= '0;
`endif
      tmo_q       <= '0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
      upd_valid_q <= 1'b0;
      upd_sel_q   <= '0;
      err_q       <= '0;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      bstate_q    <= bstate_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pstate_q    <= pstate_d;
      id_q        <= id_d;
      hi_q        <= hi_d;
`ifdef DSKY_RX_CHECKSUM_EN
      lo_q        <= lo_d;
`endif
      tmo_q       <= tmo_d;
      regs_q      <= regs_d;
      upd_valid_q <= upd_valid_d;
      upd_sel_q   <= upd_sel_d;
      err_q       <= err_d;
    end
  end

  assign DSKY_VERB_data        = regs_q[0];
  assign DSKY_NOUN_data        = regs_q[1];
  assign AXI_MISSION_TIME_data = regs_q[2];
  assign AXI_APOGEE_data       = regs_q[3];
  assign AXI_PERIGEE_data      = regs_q[4];
  assign upd_valid             = upd_valid_q;
  assign upd_sel               = upd_sel_q;
  assign err_count             = err_q;

endmodule

// File: tb/tb_dsky_serial_rx.sv
// Bench for dsky_serial_rx: random and directed UART frames against a byte-level frame model.
// Line rate is scaled down (8 clocks per bit) so saturation runs stay short.
// Commits are checked by a monitor draining an expected-commit queue.
module tb_dsky_serial_rx;
  localparam int CLK_HZ = 800_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef DSKY_RX_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [14:0] verb, noun, mtime, apogee, perigee;
  logic        upd_valid;
  logic [2:0]  upd_sel;
  logic [7:0]  err_count;

  always #5 clock = ~clock;

  dsky_serial_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(20)) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx),
    .DSKY_VERB_data(verb), .DSKY_NOUN_data(noun), .AXI_MISSION_TIME_data(mtime),
    .AXI_APOGEE_data(apogee), .AXI_PERIGEE_data(perigee),
    .upd_valid(upd_valid), .upd_sel(upd_sel), .err_count(err_count)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int dut_reg(int i);
    case (i)
      0: return int'(verb);
      1: return int'(noun);
      2: return int'(mtime);
      3: return int'(apogee);
      default: return int'(perigee);
    endcase
  endfunction

  // ---------------- reference model (byte-stream level) ----------------
  typedef struct packed { logic [2:0] sel; logic [14:0] word; } exp_t;
  logic [7:0]  fq[$];
  logic [14:0] m_regs[5];
  int          m_err = 0;
  exp_t        expq[$];

  function automatic void m_bump();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_reset();
    fq.delete();
    expq.delete();
    m_err = 0;
    for (int i = 0; i < 5; i++) m_regs[i] = '0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    bit ok;
    exp_t e;
    if (fq.size() == 0) begin
      if (b == 8'hA5) fq.push_back(b);
      return;
    end
    fq.push_back(b);
    if (fq.size() == 2 && fq[1] > 8'd4) begin
      m_bump();
      fq.delete();
    end else if (fq.size() == FLEN) begin
      ok = 1'b1;
`ifdef DSKY_RX_CHECKSUM_EN
      ok = (fq[4] == (fq[1] ^ fq[2] ^ fq[3]));
`endif
      if (ok) begin
        e.sel  = fq[1][2:0];
        e.word = {fq[2][6:0], fq[3]};
        m_regs[e.sel] = e.word;
        expq.push_back(e);
      end else begin
        m_bump();
      end
      fq.delete();
    end
  endfunction

  function automatic void model_frame_err();
    m_bump();
    fq.delete();
  endfunction

  function automatic void model_timeout();
    if (fq.size() != 0) begin
      m_bump();
      fq.delete();
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else         model_frame_err();
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  // Gaps of 0..3 bits stay inside the timeout; gaps above 12 bits always expire it.
  task automatic idle_bits(input int bits);
    rx = 1'b1;
    if (bits > 12) model_timeout();
    repeat (bits * CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] hi, input logic [7:0] lo,
                            input bit corrupt, input int gap);
    logic [7:0] cs;
    cs = id ^ hi ^ lo ^ (corrupt ? 8'h5A : 8'h00);
    send_byte(8'hA5, 1'b1); idle_bits(gap);
    send_byte(id, 1'b1);    idle_bits(gap);
    send_byte(hi, 1'b1);    idle_bits(gap);
    send_byte(lo, 1'b1);
`ifdef DSKY_RX_CHECKSUM_EN
    idle_bits(gap);
    send_byte(cs, 1'b1);
`else
    if (cs == 8'h00) idle_bits(0);
`endif
    idle_bits(1);
  endtask

  task automatic check_state(input string tag);
    repeat (4) @(negedge clock);
    check({tag, "_err_count"}, int'(err_count), m_err);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_reg%0d", tag, i), dut_reg(i), int'(m_regs[i]));
  endtask

  // ---------------- commit monitor ----------------
  bit prev_uv = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && upd_valid) begin
      check("upd_pulse_width", int'(prev_uv), 0);
      if (expq.size() == 0) begin
        check("unexpected_commit_sel", int'(upd_sel), -1);
      end else begin
        e = expq.pop_front();
        check("commit_sel", int'(upd_sel), int'(e.sel));
        check("commit_word", dut_reg(int'(upd_sel)), int'(e.word));
      end
    end
    prev_uv = reset_n && upd_valid;
  end

  // ---------------- watchdog ----------------
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int highs;
    model_reset();

    // Reset and quiet line
    rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_upd_valid", int'(upd_valid), 0);
    check("rst_upd_sel", int'(upd_sel), 0);
    check_state("rst");
    highs = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clock);
      if (upd_valid) highs++;
    end
    check("rst_idle_no_upd", highs, 0);

    // Valid frame to VERB
    send_frame(8'h00, 8'h12, 8'h34, 1'b0, 0);
    check_state("verb");
    check("verb_value", int'(verb), 15'h1234);

`ifdef DSKY_RX_CHECKSUM_EN
    // Bad checksum then good checksum to APOGEE
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h7F, 1'b1);
    send_byte(8'hFF, 1'b1); send_byte(8'h00, 1'b1); idle_bits(1);
    check_state("badcs");
    check("badcs_err", int'(err_count), 1);
    send_frame(8'h03, 8'h7F, 8'hFF, 1'b0, 0);
    check_state("goodcs");
    check("apogee_value", int'(apogee), 15'h7FFF);
`endif

    // Noise, invalid id, glitch and framing error
    send_byte(8'h5A, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h07, 1'b1); idle_bits(1);
    check_state("badid");
    rx = 1'b0;
    repeat (2) @(negedge clock);
    idle_bits(3);
    check_state("glitch");
    send_byte(8'h3C, 1'b0); idle_bits(2);
    check_state("framing");

    // Inter-byte timeout
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h01, 1'b1);
    idle_bits(25);
    check_state("timeout");

    // Reset mid-byte of a new frame
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB + 2) @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_upd_sel", int'(upd_sel), 0);
    check_state("abort");
    send_frame(8'h04, 8'h01, 8'h02, 1'b0, 0);
    check_state("perigee");
    check("perigee_value", int'(perigee), 15'h0102);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      logic [7:0] id, hi, lo;
      id = 8'($urandom_range(0, 5));
      hi = 8'($urandom);
      lo = 8'($urandom);
      send_frame(id, hi, lo, ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
      if (n % 10 == 9) check_state($sformatf("rand%0d", n));
    end

    // Saturation of err_count
    for (int n = 0; n < 280; n++) begin
      if (n % 4 == 0) begin
        send_byte(8'hA5, 1'b1);
        send_byte(8'($urandom_range(5, 255)), 1'b1);
      end else begin
        send_byte(8'($urandom), 1'b0);
      end
      idle_bits(1);
    end
    check_state("sat");
    check("sat_err_255", int'(err_count), 255);
    send_frame(8'h02, 8'($urandom), 8'($urandom), 1'b0, 1);
    check_state("post_sat");
    check("post_sat_err_255", int'(err_count), 255);

    repeat (20) @(negedge clock);
    check("exp_queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
